// File: rtl/mlp_pkg.sv
// Shared constants, state type and sizing helper for the dense layer MAC.
package mlp_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int FRAC_BITS_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DONE
    } mac_state_t;

    // Headroom for summing input_width full-precision products without overflow.
    function automatic int acc_width(input int data_width, input int input_width);
        return 2 * data_width + $clog2(input_width);
    endfunction

endpackage

// File: rtl/dense_rescale.sv
// Fixed-point rescale: floor shift by FRAC_BITS, then width reduction to DATA_WIDTH.
// DENSE_MAC_SAT_EN selects clamping; otherwise the result wraps (two's complement).
module dense_rescale #(
    parameter int IN_WIDTH   = 35,
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8
) (
    input  logic signed [IN_WIDTH-1:0]   value,
    output logic signed [DATA_WIDTH-1:0] result
);

    logic signed [IN_WIDTH-1:0] shifted;

    assign shifted = value >>> FRAC_BITS;

`ifdef DENSE_MAC_SAT_EN
    localparam logic signed [IN_WIDTH-1:0] MAX_V =
        {{(IN_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] MIN_V =
        {{(IN_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    always_comb begin
        result = DATA_WIDTH'(shifted);
        if (shifted > MAX_V) begin
            result = DATA_WIDTH'(MAX_V);
        end else if (shifted < MIN_V) begin
            result = DATA_WIDTH'(MIN_V);
        end
    end
`else
    assign result = DATA_WIDTH'(shifted);
`endif

endmodule

// File: rtl/dense_mac.sv
// Sequential dense layer: one weight*activation product per cycle, neuron by neuron.
// Width reduction of each result is configured by DENSE_MAC_SAT_EN (see dense_rescale).
module dense_mac
    import mlp_pkg::*;
#(
    parameter int INPUT_WIDTH  = 3,
    parameter int OUTPUT_WIDTH = 3,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int FRAC_BITS    = FRAC_BITS_DEF
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] x_in  [INPUT_WIDTH],
    input  logic signed [DATA_WIDTH-1:0] w_in  [OUTPUT_WIDTH][INPUT_WIDTH],
    input  logic signed [DATA_WIDTH-1:0] b_in  [OUTPUT_WIDTH],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] y_out [OUTPUT_WIDTH]
);

    localparam int ACC_W = acc_width(DATA_WIDTH, INPUT_WIDTH);
    localparam int SUM_W = ACC_W + 1;
    localparam int IW_B  = (INPUT_WIDTH  > 1) ? $clog2(INPUT_WIDTH)  : 1;
    localparam int OW_B  = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1;

    mac_state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0]   x_reg [INPUT_WIDTH];
    logic signed [ACC_W-1:0]        acc;
    logic        [IW_B-1:0]         i;
    logic        [OW_B-1:0]         j;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [SUM_W-1:0]        sum;
    logic signed [DATA_WIDTH-1:0]   y_new;
    logic                           last_i;
    logic                           last_j;

    assign last_i = (i == IW_B'(INPUT_WIDTH - 1));
    assign last_j = (j == OW_B'(OUTPUT_WIDTH - 1));
    assign prod   = w_in[j][i] * x_reg[i];
    assign sum    = SUM_W'(acc) + SUM_W'(prod) + (SUM_W'(b_in[j]) <<< FRAC_BITS);

    dense_rescale #(
        .IN_WIDTH   (SUM_W),
        .DATA_WIDTH (DATA_WIDTH),
        .FRAC_BITS  (FRAC_BITS)
    ) u_rescale (
        .value  (sum),
        .result (y_new)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = MAC;
                end
            end
            MAC: begin
                if (last_i && last_j) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The bias joins on the last product of each neuron, so the accumulator never sees it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            i     <= '0;
            j     <= '0;
            x_reg <= '{default: '0};
            y_out <= '{default: '0};
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        x_reg <= x_in;
                        acc   <= '0;
                        i     <= '0;
                        j     <= '0;
                    end
                end
                MAC: begin
                    if (last_i) begin
                        y_out[j] <= y_new;
                        acc      <= '0;
                        i        <= '0;
                        j        <= last_j ? '0 : j + OW_B'(1);
                    end else begin
                        acc <= acc + ACC_W'(prod);
                        i   <= i + IW_B'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
